// File: rtl/move_input.sv
// move_input: debounces four raw direction buttons and turns each debounced press into a
// single move command held in a one-entry valid/ready output register.
module move_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       overrun,
    output logic [3:0] btn_stable
);

    localparam logic [19:0] CntMax = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StEmpty, StFull} state_e;

    logic [3:0]  raw;
    logic [3:0]  sync1_q, sync2_q;
    logic [19:0] cnt_q [4];
    logic [19:0] cnt_d [4];
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  stable_prev_q;
    logic [3:0]  press;
    logic        ev_valid;
    logic [1:0]  ev_dir;
    state_e      state_q, state_d;
    logic        load_dir;
    logic        overrun_d;
    logic [1:0]  dir_q;
    logic        overrun_q;

    // Bit order matches btn_stable and the move code: {right,left,down,up}
    assign raw = {right, left, down, up};

    // Two-flop synchronizers on every raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: count cycles the synchronized level disagrees with the stable level
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CntMax) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + 20'd1;
            end
        end
    end

    // Debounce counters, stable levels and the previous stable level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= '0;
            end
            stable_q      <= '0;
            stable_prev_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    assign btn_stable = stable_q;

    // Press events are debounced rising edges; priority up > down > left > right
    always_comb begin
        press    = stable_q & ~stable_prev_q;
        ev_valid = |press;
        if (press[0]) begin
            ev_dir = 2'd0;
        end else if (press[1]) begin
            ev_dir = 2'd1;
        end else if (press[2]) begin
            ev_dir = 2'd2;
        end else begin
            ev_dir = 2'd3;
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (ev_valid) state_d = StFull;
            StFull:  if (move_ready && !ev_valid) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Output FSM outputs: register load and overrun detection
    always_comb begin
        move_valid = (state_q == StFull);
        load_dir   = 1'b0;
        overrun_d  = 1'b0;
        case (state_q)
            StEmpty: load_dir = ev_valid;
            StFull: begin
                load_dir  = ev_valid && move_ready;
                overrun_d = ev_valid && !move_ready;
            end
            default: ;
        endcase
    end

    // Move code register and one-cycle overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (load_dir) begin
                dir_q <= ev_dir;
            end
            overrun_q <= overrun_d;
        end
    end

    assign move_dir = dir_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/move_input.md
MOVE_INPUT -- requirements
Module: move_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), giving the number of cycles a synchronized level must hold before it is accepted; legal range 2..1048575.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port up, input, 1, raw asynchronous button, active high.
REQ-005 SHALL have port down, input, 1, raw asynchronous button, active high.
REQ-006 SHALL have port left, input, 1, raw asynchronous button, active high.
REQ-007 SHALL have port right, input, 1, raw asynchronous button, active high.
REQ-008 SHALL have port move_valid, output, 1, meaning a move command is presented.
REQ-009 SHALL have port move_dir, output, 2, move code: 0=up, 1=down, 2=left, 3=right.
REQ-010 SHALL have port move_ready, input, 1, meaning the game loop accepts the move this cycle.
REQ-011 SHALL have port overrun, output, 1, a one-cycle pulse when a press is discarded because the output is full.
REQ-012 SHALL have port btn_stable, output, 4, the debounced levels {right,left,down,up}.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer before any other logic.
REQ-014 SHALL keep a 20-bit counter per button, cleared whenever the synchronized level equals btn_stable, incremented otherwise.
REQ-015 SHALL update btn_stable to the synchronized level and clear the counter when the counter reaches DEBOUNCE_CYCLES-1 with the level still differing.
REQ-016 SHALL generate a press event only on a 0->1 transition of btn_stable; releases and held levels generate nothing.
REQ-017 SHALL resolve same-cycle press events by priority up>down>left>right and silently discard the lower-priority events, without pulsing overrun.
REQ-018 SHALL implement a one-entry output register controlled by a 2-state FSM, EMPTY and FULL.
REQ-019 EMPTY: on a press event SHALL load move_dir and go to FULL, so move_valid is high on the next cycle.
REQ-020 FULL: SHALL hold move_valid=1 and keep move_dir constant until move_valid&&move_ready.
REQ-021 FULL with a handshake and no event SHALL go to EMPTY, so move_valid is low on the next cycle.
REQ-022 FULL with a handshake and an event in the same cycle SHALL load the new move_dir and remain FULL.
REQ-023 FULL with no handshake and an event SHALL discard the event, keep move_dir, and pulse overrun high for exactly the next cycle.
REQ-024 SHALL ignore move_ready while EMPTY.
REQ-025 Latency: a clean raw rising level held constant SHALL produce move_valid high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high, with the output EMPTY.
REQ-026 SHALL produce exactly one move per debounced press, however long the button is held.

Reset
REQ-027 While rst=1, SHALL asynchronously force the synchronizers, counters, btn_stable, move_dir, move_valid and overrun to 0 and the FSM to EMPTY.
REQ-028 A button still held when rst deasserts SHALL be treated as a new press: one move after the REQ-025 latency.
REQ-029 Reset asserted mid-handshake SHALL discard the pending move with no partial output.

Verification (DEBOUNCE_CYCLES=4, so latency=7)
REQ-030 Release reset, hold up for 20 cycles with move_ready=1: move_valid=1 for exactly one cycle at edge 7 with move_dir=0; no further move while held or on release.
REQ-031 Toggle right every 2 cycles for 10 cycles, then hold: exactly one move with move_dir=3, 7 edges after the final rise; overrun stays 0.
REQ-032 Raise down and left in the same cycle and hold: one move with move_dir=1; left produces no move and no overrun.
REQ-033 Hold move_ready=0, press up, then left after move_valid is high: move_dir stays 0, overrun pulses once; then move_ready=1 for 1 cycle: move_valid falls the next cycle.
REQ-034 With move_valid=1 (move_dir=0), time a down press event to coincide with move_ready=1: move_valid stays 1, move_dir becomes 1 on the next cycle, overrun stays 0.
REQ-035 Assert rst for 3 cycles while move_valid=1 and up is held: all outputs are 0 immediately; after release, move_dir=0 with move_valid at edge 7.
